// File: rtl/ifid_fetch_ctrl.sv
// IF/ID fetch sequencer: owns the PC, runs a single-outstanding imem handshake and feeds the IF/ID register.
// Optional perf counters (perf_fetched, perf_stall) are built when IFID_FETCH_PERF_EN is defined.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | first cycle after reset, no request yet
// REQ    | imem_req high at pc, waiting for imem_gnt
// WAIT   | request granted, waiting for imem_rvalid (timeout counter runs)
// HOLD   | response parked in hold buffer while the IF/ID slot is stalled
module ifid_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
`ifdef IFID_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [7:0]  WAIT_TC = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic        deliver;
    logic        slot_free;

    assign slot_free = !id_valid_q || id_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        id_valid_d  = id_valid_q && !id_ready;
        id_inst_d   = id_inst_q;
        id_pc_d     = id_pc_q;
        fetch_err_d = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    // a granted request cannot be withdrawn, so a same-cycle redirect marks it for discard
                    state_d = S_WAIT;
                    cnt_d   = WAIT_TC;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        id_inst_d = imem_rdata;
                        deliver   = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (cnt_q == 8'd0) begin
                    fetch_err_d = !redirect_valid;
                    drop_d      = 1'b0;
                    state_d     = S_REQ;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (redirect_valid) drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (id_ready) begin
                    id_inst_d = hold_q;
                    deliver   = 1'b1;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (deliver) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
        end

        if (redirect_valid && state_q != S_IDLE) begin
            pc_d       = redirect_pc & ~32'd3;
            id_valid_d = 1'b0;
            hold_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            id_valid_q  <= 1'b0;
            id_inst_q   <= NOP;
            id_pc_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign fetch_err = fetch_err_q;

`ifdef IFID_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (deliver && perf_fetched_q != 32'hFFFF_FFFF) perf_fetched_d = perf_fetched_q + 32'd1;
        if (id_valid_q && !id_ready && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifid_fetch_ctrl.sv
// Self-checking bench for ifid_fetch_ctrl: directed scenarios plus a randomized run against a PC-stream scoreboard.
module tb_ifid_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          MAXW   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_err;
`ifdef IFID_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifid_fetch_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_err     (fetch_err)
`ifdef IFID_FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    // instruction memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    // leaves the bench at a negedge with rst_n just released; the next posedge is edge 1
    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // zero-wait memory: grant immediately, answer on the first WAIT cycle
    task automatic zw(input logic rdy);
        cyc(1'b1, 1'b1, mem_word(imem_addr), rdy, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RST_PC); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", id_valid); end
        total++; if (id_inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h want=00000013", id_inst); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", id_pc); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", fetch_err); end
    endtask

    task automatic test_stream();
        logic        ev;
        logic [31:0] ep;
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            zw(1'b1);
            ev = (k >= 3) && (k % 2 == 1);
            ep = RST_PC + 32'(4 * ((k - 3) / 2));
            total++;
            if (id_valid !== ev) begin bad++; $display("FAIL stream_valid edge=%0d got=%b want=%b", k, id_valid, ev); end
            if (ev) begin
                total++;
                if (id_pc !== ep || id_inst !== mem_word(ep)) begin
                    bad++; $display("FAIL stream_data edge=%0d got_pc=%h got_inst=%h want_pc=%h want_inst=%h",
                                    k, id_pc, id_inst, ep, mem_word(ep));
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        repeat (3) zw(1'b1);
        for (int i = 0; i < 5; i++) begin
            zw(1'b0);
            total++;
            if (id_valid !== 1'b1 || id_pc !== RST_PC || id_inst !== mem_word(RST_PC)) begin
                bad++; $display("FAIL stall_stable cyc=%0d got_v=%b got_pc=%h got_inst=%h want_pc=%h",
                                i, id_valid, id_pc, id_inst, RST_PC);
            end
        end
`ifdef IFID_FETCH_PERF_EN
        total++; if (perf_stall !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d want=5", perf_stall); end
`endif
        zw(1'b1);
        total++;
        if (id_valid !== 1'b1 || id_pc !== RST_PC + 32'd4 || id_inst !== mem_word(RST_PC + 32'd4)) begin
            bad++; $display("FAIL stall_release got_v=%b got_pc=%h got_inst=%h want_pc=%h",
                            id_valid, id_pc, id_inst, RST_PC + 32'd4);
        end
        zw(1'b1);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stall_nodup got=%b want=0", id_valid); end
        zw(1'b1);
        total++;
        if (id_valid !== 1'b1 || id_pc !== RST_PC + 32'd8 || id_inst !== mem_word(RST_PC + 32'd8)) begin
            bad++; $display("FAIL stall_next got_v=%b got_pc=%h want_pc=%h", id_valid, id_pc, RST_PC + 32'd8);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h203);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_still_wait got=%b want=0", imem_req); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rdw_dropped got=%b want=0", id_valid); end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL rdw_addr got_req=%b got_addr=%h want=1/00000200", imem_req, imem_addr);
        end
        zw(1'b1);
        zw(1'b1);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== mem_word(32'h200)) begin
            bad++; $display("FAIL rdw_deliver got_v=%b got_pc=%h got_inst=%h want_pc=00000200", id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_redirect_gnt();
        apply_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdg_wait got=%b want=0", imem_req); end
        cyc(1'b0, 1'b1, mem_word(RST_PC), 1'b1, 1'b0, 32'h0);
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++; $display("FAIL rdg_discard got_v=%b got_req=%b got_addr=%h want=0/1/00000300", id_valid, imem_req, imem_addr);
        end
        zw(1'b1);
        zw(1'b1);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_inst !== mem_word(32'h300)) begin
            bad++; $display("FAIL rdg_deliver got_v=%b got_pc=%h want_pc=00000300", id_valid, id_pc);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        apply_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 1; i < MAXW; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            if (fetch_err !== 1'b0 || imem_req !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL to_early got=%0d want=0", early); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", fetch_err); end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL to_refetch got_req=%b got_addr=%h want_addr=%h", imem_req, imem_addr, RST_PC);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b want=0", fetch_err); end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL to_req_hold got_req=%b got_addr=%h", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        repeat (3) zw(1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || id_valid !== 1'b0 ||
            id_inst !== 32'h0000_0013 || id_pc !== 32'h0 || fetch_err !== 1'b0) begin
            bad++; $display("FAIL rmw_reset got_req=%b addr=%h v=%b inst=%h pc=%h err=%b",
                            imem_req, imem_addr, id_valid, id_inst, id_pc, fetch_err);
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL rmw_late got_v=%b got_req=%b got_addr=%h", id_valid, imem_req, imem_addr);
        end
        zw(1'b1);
        zw(1'b1);
        total++;
        if (id_valid !== 1'b1 || id_pc !== RST_PC || id_inst !== mem_word(RST_PC)) begin
            bad++; $display("FAIL rmw_restart got_v=%b got_pc=%h got_inst=%h", id_valid, id_pc, id_inst);
        end
    endtask

    // random memory latency, back-pressure and redirects; consumed stream must follow the PC rules
    task automatic test_random();
        logic [31:0] exp_pc, oaddr, prev_pc, prev_inst, rpc, rd;
        logic        outstanding, prev_stall, rdy, redir, g, rv;
        int          lat, delivered, errs;
        exp_pc = RST_PC; outstanding = 1'b0; oaddr = '0; lat = 0;
        prev_stall = 1'b0; prev_pc = '0; prev_inst = '0; delivered = 0; errs = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (prev_stall) begin
                total++;
                if (id_valid !== 1'b1 || id_pc !== prev_pc || id_inst !== prev_inst) begin
                    bad++; $display("FAIL rnd_stall cyc=%0d got_v=%b got_pc=%h want_pc=%h", c, id_valid, id_pc, prev_pc);
                end
            end
            if (fetch_err !== 1'b0) errs++;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = (c >= 2) && ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rv = 1'b0;
            rd = $urandom;
            if (outstanding) begin
                if (lat == 0) begin
                    rv = 1'b1; rd = mem_word(oaddr); outstanding = 1'b0;
                end else begin
                    lat--;
                end
            end
            g = imem_req && ($urandom_range(0, 9) < 7);
            if (g) begin
                outstanding = 1'b1; lat = $urandom_range(0, 3); oaddr = imem_addr;
            end
            if (id_valid === 1'b1 && rdy) begin
                total++;
                if (id_pc !== exp_pc || id_inst !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rnd_stream cyc=%0d got_pc=%h got_inst=%h want_pc=%h want_inst=%h",
                                    c, id_pc, id_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redir) exp_pc = rpc & ~32'd3;
            prev_stall = (id_valid === 1'b1) && !rdy && !redir;
            prev_pc    = id_pc;
            prev_inst  = id_inst;
            cyc(g, rv, rd, rdy, redir, rpc);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rnd_no_timeout got=%0d want=0", errs); end
        total++; if (delivered < 200) begin bad++; $display("FAIL rnd_progress got=%0d want>=200", delivered); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_gnt();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
